// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline-register types, bubble constant and fetch FSM states
package pipeline_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;
  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0, valid: 1'b0};
  typedef enum logic {BOOT, RUN} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with reset, flush (to bubble), load and hold
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);
  always_ff @(posedge clk)
    q <= (!rst_n || flush) ? BUBBLE : load ? d : q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, next-PC selection and IF/ID register with stall/flush counters
module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SignalPC,
  input  logic             Redirect,
  input  logic [XLEN-1:0]  RedirectPC,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ifid_instr,
  output logic [XLEN-1:0]  ifid_pc,
  output logic [XLEN-1:0]  ifid_pc4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  fetch_state_t state;
  logic [XLEN-1:0] pc, pc4;
  logic run, redir, stall;
  if_id_t d, q;
  assign run = state == RUN;
  assign redir = run && Redirect;
  assign stall = run && SignalPC && !Redirect;
  assign pc4 = pc + XLEN'(4);
  assign imem_addr = pc;
  assign d = '{instr: imem_rdata, pc: pc, pc4: pc4, valid: 1'b1};
  // BOOT always loads a bubble so imem has a cycle to settle
  if_id_reg u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (!stall),
    .flush (!run || redir),
    .d     (d),
    .q     (q)
  );
  assign ifid_instr = q.instr;
  assign ifid_pc = q.pc;
  assign ifid_pc4 = q.pc4;
  assign ifid_valid = q.valid;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= BOOT;
      pc <= RESET_PC;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= RUN;
      pc <= redir ? RedirectPC : (run && !stall) ? pc4 : pc;
      stall_cnt <= (stall && !(&stall_cnt)) ? stall_cnt + CNT_W'(1) : stall_cnt;
      flush_cnt <= (redir && !(&flush_cnt)) ? flush_cnt + CNT_W'(1) : flush_cnt;
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed + random stimulus on two instances (reset PC 0 and FFFF_FFFC) against a behavioural model
module tb_if_fetch_stage;
  logic clk = 0, rst_n = 0, SignalPC = 0, Redirect = 0;
  logic [31:0] RedirectPC = 0;
  logic [31:0] a0, r0, i0, p0, q0, s0, f0, a1, r1, i1, p1, q1, s1, f1;
  logic v0, v1;
  int passed = 0, total = 0, cyc = 0;
  logic [31:0] m_pc[2], m_instr[2], m_ipc[2], m_ipc4[2], m_sc[2], m_fc[2];
  logic m_valid[2], m_boot[2];
  localparam logic [31:0] RPC[2] = '{32'h0, 32'hFFFF_FFFC};

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction
  assign r0 = mem(a0);
  assign r1 = mem(a1);

  if_fetch_stage u0 (.clk(clk), .rst_n(rst_n), .SignalPC(SignalPC), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .imem_addr(a0), .imem_rdata(r0), .ifid_instr(i0), .ifid_pc(p0),
    .ifid_pc4(q0), .ifid_valid(v0), .stall_cnt(s0), .flush_cnt(f0));
  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u1 (.clk(clk), .rst_n(rst_n), .SignalPC(SignalPC),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .imem_addr(a1), .imem_rdata(r1),
    .ifid_instr(i1), .ifid_pc(p1), .ifid_pc4(q1), .ifid_valid(v1), .stall_cnt(s1), .flush_cnt(f1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
  endtask

  task automatic bubble(input int k);
    m_instr[k] = 32'h13; m_ipc[k] = 0; m_ipc4[k] = 0; m_valid[k] = 0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++)
      if (!rst_n) begin
        m_pc[k] = RPC[k]; bubble(k); m_sc[k] = 0; m_fc[k] = 0; m_boot[k] = 1;
      end else if (m_boot[k]) begin
        bubble(k); m_boot[k] = 0;
      end else if (Redirect) begin
        m_pc[k] = RedirectPC; bubble(k);
        if (m_fc[k] != 32'hFFFF_FFFF) m_fc[k]++;
      end else if (SignalPC) begin
        if (m_sc[k] != 32'hFFFF_FFFF) m_sc[k]++;
      end else begin
        m_instr[k] = mem(m_pc[k]); m_ipc[k] = m_pc[k]; m_ipc4[k] = m_pc[k] + 4;
        m_valid[k] = 1; m_pc[k] = m_pc[k] + 4;
      end
  endtask

  task automatic check_inst(input int k, input logic [31:0] a, i, p, q, input logic v,
                            input logic [31:0] s, f);
    check($sformatf("u%0d.imem_addr", k), a, m_pc[k]);
    check($sformatf("u%0d.ifid_instr", k), i, m_instr[k]);
    check($sformatf("u%0d.ifid_pc", k), p, m_ipc[k]);
    check($sformatf("u%0d.ifid_pc4", k), q, m_ipc4[k]);
    check($sformatf("u%0d.ifid_valid", k), {31'b0, v}, {31'b0, m_valid[k]});
    check($sformatf("u%0d.stall_cnt", k), s, m_sc[k]);
    check($sformatf("u%0d.flush_cnt", k), f, m_fc[k]);
  endtask

  task automatic cycle(input logic rn, input logic sp, input logic rd, input logic [31:0] rpc);
    rst_n = rn; SignalPC = sp; Redirect = rd; RedirectPC = rpc;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_inst(0, a0, i0, p0, q0, v0, s0, f0);
    check_inst(1, a1, i1, p1, q1, v1, s1, f1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin m_boot[k] = 1; m_pc[k] = RPC[k]; bubble(k); m_sc[k] = 0; m_fc[k] = 0; end
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 32'h40);
    cycle(1, 1, 1, 32'h80);
    repeat (3) cycle(1, 0, 0, 0);
    check("ifid_pc_8_before_stall", p0, 32'h8);
    repeat (2) cycle(1, 1, 0, 0);
    check("stall_holds_addr", a0, 32'hC);
    check("stall_cnt_two", s0, 32'd2);
    repeat (6) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 32'h100);
    check("redirect_addr", a0, 32'h100);
    cycle(1, 0, 0, 0);
    check("redirect_target_pc", p0, 32'h100);
    cycle(1, 1, 1, 32'h203);
    cycle(1, 0, 0, 0);
    repeat (2) cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("reset_in_stall_valid", {31'b0, v0}, 32'h0);
    repeat (3) cycle(1, 0, 0, 0);
    repeat (600) begin
      logic rn, sp, rd;
      rn = $urandom_range(0, 59) != 0;
      sp = $urandom_range(0, 3) == 0;
      rd = $urandom_range(0, 7) == 0;
      cycle(rn, sp, rd, $urandom);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
